// File: rtl/clock_pkg.sv
// Shared mode/state encoding for the clock mode controller.
package clock_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector against the previous-cycle sample.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise_c = din & ~prev;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Run/set mode controller for a HH:MM:SS clock: counter enables, inc auto-repeat, blink.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 50_000_000,
    parameter int unsigned REPEAT_PER = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1hz,
    input  logic                rco_sec,
    input  logic                rco_min,
    input  logic                btn_mode,
    input  logic                btn_inc,
    output logic                en_sec,
    output logic                en_min,
    output logic                en_hr,
    output logic                clr_sec,
    output logic [MODE_W-1:0]   mode,
    output logic                blink
);

    localparam int unsigned CNT_W = $clog2(max_u(REPEAT_DLY, REPEAT_PER)) + 1;

    mode_e             state_q, state_d;
    logic              en_sec_q, en_sec_d;
    logic              en_min_q, en_min_d;
    logic              en_hr_q, en_hr_d;
    logic              clr_sec_q, clr_sec_d;
    logic              blink_q, blink_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rpt_phase_q, rpt_phase_d;
    logic              inc_block_q, inc_block_d;

    logic              mode_rise_c;
    logic              inc_rise_c;
    logic [CNT_W-1:0]  rpt_thr_c;
    logic              rpt_hit_c;
    logic              inc_c;

    edge_detect u_mode_edge (.clk(clk), .rst(rst), .din(btn_mode), .rise_c(mode_rise_c));
    edge_detect u_inc_edge  (.clk(clk), .rst(rst), .din(btn_inc),  .rise_c(inc_rise_c));

    // First repeat waits REPEAT_DLY after the press, later ones REPEAT_PER apart
    assign rpt_thr_c = rpt_phase_q ? CNT_W'(REPEAT_PER) : CNT_W'(REPEAT_DLY);
    assign rpt_hit_c = btn_inc & ~inc_rise_c & ~inc_block_q & (cnt_q == rpt_thr_c);
    assign inc_c     = (inc_rise_c & ~inc_block_q) | rpt_hit_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            en_sec_q    <= 1'b0;
            en_min_q    <= 1'b0;
            en_hr_q     <= 1'b0;
            clr_sec_q   <= 1'b0;
            blink_q     <= 1'b0;
            cnt_q       <= '0;
            rpt_phase_q <= 1'b0;
            inc_block_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_sec_q    <= en_sec_d;
            en_min_q    <= en_min_d;
            en_hr_q     <= en_hr_d;
            clr_sec_q   <= clr_sec_d;
            blink_q     <= blink_d;
            cnt_q       <= cnt_d;
            rpt_phase_q <= rpt_phase_d;
            inc_block_q <= inc_block_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        en_sec_d    = 1'b0;
        en_min_d    = 1'b0;
        en_hr_d     = 1'b0;
        clr_sec_d   = 1'b0;
        blink_d     = blink_q;
        cnt_d       = cnt_q;
        rpt_phase_d = rpt_phase_q;

        // A mode press that collides with an inc locks inc out until btn_inc is released
        inc_block_d = btn_inc & (inc_block_q | (mode_rise_c & inc_c));

        if (!btn_inc || inc_block_q || (mode_rise_c && inc_c)) begin
            cnt_d       = '0;
            rpt_phase_d = 1'b0;
        end else if (rpt_hit_c) begin
            cnt_d       = CNT_W'(1);
            rpt_phase_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (mode_rise_c) begin
            blink_d = 1'b0;
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = SET_SEC;
                default: state_d = RUN;
            endcase
        end else begin
            case (state_q)
                RUN: begin
                    blink_d  = 1'b0;
                    en_sec_d = tick_1hz;
                    en_min_d = tick_1hz & rco_sec;
                    en_hr_d  = tick_1hz & rco_sec & rco_min;
                end
                SET_HR:  en_hr_d   = inc_c;
                SET_MIN: en_min_d  = inc_c;
                default: clr_sec_d = inc_c;
            endcase
            if (state_q != RUN && tick_1hz) blink_d = ~blink_q;
        end
    end

    assign mode    = state_q;
    assign en_sec  = en_sec_q;
    assign en_min  = en_min_q;
    assign en_hr   = en_hr_q;
    assign clr_sec = clr_sec_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed-vector bench for clock_mode_ctrl with a short repeat timing.
module tb_clock_mode_ctrl;

    localparam int unsigned DLY = 10;
    localparam int unsigned PER = 4;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, rco_sec, rco_min, btn_mode, btn_inc;
    logic       en_sec, en_min, en_hr, clr_sec, blink;
    logic [1:0] mode;

    int n_vec = 0;
    int n_err = 0;

    clock_mode_ctrl #(.REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .rco_sec(rco_sec), .rco_min(rco_min),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .en_sec(en_sec), .en_min(en_min),
        .en_hr(en_hr), .clr_sec(clr_sec), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {mode, en_sec, en_min, en_hr, clr_sec, blink}
    function automatic logic [6:0] outs();
        return {mode, en_sec, en_min, en_hr, clr_sec, blink};
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (mode,sec,min,hr,clr,blink)", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode(input logic [1:0] exp_m);
        btn_mode = 1'b1;
        step();
        chk("mode_step", outs(), {exp_m, 5'b00000});
        btn_mode = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; rco_sec = 1'b0; rco_min = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0;
        step(); step();
        chk("reset", outs(), 7'b0);

        // reset overrides a simultaneous mode press and tick
        btn_mode = 1'b1; tick_1hz = 1'b1; rco_sec = 1'b1;
        step();
        chk("reset_prio", outs(), 7'b0);
        rst = 1'b0; btn_mode = 1'b0; tick_1hz = 1'b0; rco_sec = 1'b0;
        step();

        // run-mode carry chain
        tick_1hz = 1'b1; rco_sec = 1'b1; rco_min = 1'b1;
        step();
        chk("run_carry", outs(), {2'd0, 5'b11100});
        tick_1hz = 1'b0;
        step();
        chk("run_carry_off", outs(), 7'b0);
        tick_1hz = 1'b1; rco_min = 1'b0;
        step();
        chk("run_sec_min", outs(), {2'd0, 5'b11000});
        tick_1hz = 1'b0; rco_sec = 1'b0;
        step();
        chk("run_idle", outs(), 7'b0);
        tick_1hz = 1'b1; rco_min = 1'b1;
        step();
        chk("run_sec_only", outs(), {2'd0, 5'b10000});
        tick_1hz = 1'b0; rco_min = 1'b0;
        step();

        // mode cycling; ticks in set states only toggle blink
        press_mode(2'd1);
        tick_1hz = 1'b1;
        step();
        chk("set_hr_tick", outs(), {2'd1, 5'b00001});
        tick_1hz = 1'b0;
        step();
        chk("set_hr_hold", outs(), {2'd1, 5'b00001});
        press_mode(2'd2);
        tick_1hz = 1'b1;
        step();
        chk("set_min_tick", outs(), {2'd2, 5'b00001});
        tick_1hz = 1'b0;
        press_mode(2'd3);
        tick_1hz = 1'b1;
        step();
        chk("set_sec_tick", outs(), {2'd3, 5'b00001});
        tick_1hz = 1'b0;
        press_mode(2'd0);
        step();
        chk("run_reentry", outs(), 7'b0);

        // single inc in SET_MIN and SET_SEC
        press_mode(2'd1);
        press_mode(2'd2);
        rco_min = 1'b1;
        btn_inc = 1'b1;
        step();
        chk("set_min_inc", outs(), {2'd2, 5'b01000});
        step();
        chk("set_min_inc_off", outs(), {2'd2, 5'b00000});
        btn_inc = 1'b0; rco_min = 1'b0;
        step();
        press_mode(2'd3);
        btn_inc = 1'b1;
        step();
        chk("set_sec_clr", outs(), {2'd3, 5'b00010});
        step();
        chk("set_sec_clr_off", outs(), {2'd3, 5'b00000});
        btn_inc = 1'b0;
        step();
        press_mode(2'd0);

        // auto-repeat in SET_HR: pulses at press+1, +11, +15, +19, +23
        press_mode(2'd1);
        btn_inc = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            logic hr;
            step();
            hr = (c == 1 || c == 11 || c == 15 || c == 19 || c == 23);
            chk("repeat_hr", outs(), {2'd1, 2'b00, hr, 2'b00});
            if (c == 25) btn_inc = 1'b0;
        end

        // mode press and inc rise together: mode wins, held inc stays locked out
        btn_mode = 1'b1; btn_inc = 1'b1;
        step();
        chk("collide", outs(), {2'd2, 5'b00000});
        btn_mode = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            chk("collide_hold", outs(), {2'd2, 5'b00000});
        end
        btn_inc = 1'b0;
        step();
        chk("collide_release", outs(), {2'd2, 5'b00000});
        btn_inc = 1'b1;
        step();
        chk("collide_repress", outs(), {2'd2, 5'b01000});
        btn_inc = 1'b0;
        step();
        chk("collide_repress_off", outs(), {2'd2, 5'b00000});

        // reset during a held-inc repeat in SET_MIN
        btn_inc = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            logic mn;
            step();
            mn = (c == 1 || c == 11);
            chk("rst_pre_repeat", outs(), {2'd2, 1'b0, mn, 3'b000});
        end
        rst = 1'b1;
        step();
        chk("rst_mid_set", outs(), 7'b0);
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            chk("rst_after", outs(), 7'b0);
        end
        btn_inc = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter REPEAT_DLY SHALL default to 50_000_000 and set the inc hold time, in cycles, before auto-repeat starts.
REQ-003 Parameter REPEAT_PER SHALL default to 10_000_000 and set the auto-repeat period in cycles; it SHALL be at least 2.
REQ-004 Port clk SHALL be an input, 1 bit: the system clock.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Port tick_1hz SHALL be an input, 1 bit: a one-cycle pulse once per second.
REQ-007 Port rco_sec SHALL be an input, 1 bit: the seconds counter is at 59.
REQ-008 Port rco_min SHALL be an input, 1 bit: the minutes counter is at 59.
REQ-009 Port btn_mode SHALL be an input, 1 bit: debounced mode button level.
REQ-010 Port btn_inc SHALL be an input, 1 bit: debounced increment button level.
REQ-011 Ports en_sec, en_min and en_hr SHALL be outputs, 1 bit each: one-cycle count enables to the time counters.
REQ-012 Port clr_sec SHALL be an output, 1 bit: one-cycle synchronous clear of the seconds counter.
REQ-013 Port mode SHALL be an output, 2 bits: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
REQ-014 Port blink SHALL be an output, 1 bit: display blank phase for the field being edited.

Function
REQ-015 FSM states SHALL be RUN, SET_HR, SET_MIN and SET_SEC; mode SHALL equal the state encoding.
REQ-016 Transitions SHALL occur only on a btn_mode rising edge, in the order RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN, taking effect the next cycle.
REQ-017 Rising edges SHALL be detected against the previous-cycle register of each button.
REQ-018 In RUN, when tick_1hz=1 in cycle N: en_sec=1 in cycle N+1; en_min=1 if rco_sec was 1 in cycle N; en_hr=1 if rco_sec and rco_min were both 1 in cycle N.
REQ-019 In any SET state, tick_1hz SHALL be ignored, so time halts.
REQ-020 In SET_HR and SET_MIN, each inc pulse SHALL assert only en_hr or en_min, respectively, for one cycle; no carry SHALL propagate, and wrap is handled by the counter.
REQ-021 In SET_SEC, each inc pulse SHALL assert clr_sec for one cycle, with no en_sec.
REQ-022 An inc pulse SHALL be generated in the cycle after a btn_inc rising edge.
REQ-023 With btn_inc held, the next inc pulse SHALL follow REPEAT_DLY cycles after the first, then one every REPEAT_PER cycles.
REQ-024 Releasing btn_inc SHALL clear the repeat counter.
REQ-025 If a btn_mode edge and an inc pulse occur in the same cycle, mode SHALL win: no enable or clear, the repeat counter clears, and a still-held btn_inc produces no pulse until it is released and pressed again.
REQ-026 Entering RUN SHALL NOT assert any enable until the next tick_1hz.
REQ-027 blink SHALL toggle on each tick_1hz while in a SET state, and SHALL be 0 in RUN and on every state change.
REQ-028 All outputs SHALL be registered.
REQ-029 At most one of en_min, en_hr and clr_sec SHALL be high in any SET-state cycle.

Reset
REQ-030 On rst=1, the state SHALL become RUN; en_*, clr_sec, blink and mode SHALL be 0; the repeat counter and edge registers SHALL be 0.
REQ-031 rst SHALL take priority over all inputs.
REQ-032 A reset mid-SET SHALL return to RUN with no pending pulse.

Structure
REQ-033 Package clock_pkg SHALL hold the state/mode encoding constants RUN, SET_HR, SET_MIN and SET_SEC.
REQ-034 Sub-module edge_detect (1-bit rising-edge detector, clk/rst) SHALL be instantiated twice.
REQ-035 The repeat counter width SHALL be clog2(max(REPEAT_DLY, REPEAT_PER)) + 1.

Verification
REQ-036 Run carry: RUN, rco_sec=1, rco_min=1, tick pulse -> en_sec, en_min and en_hr all =1 exactly one cycle later, then 0.
REQ-037 Mode cycling: 4 btn_mode presses -> mode sequence 1, 2, 3, 0; ticks during mode 1-3 -> no en_*.
REQ-038 Set minutes: mode=2, rco_min=1, single inc press -> en_min=1 for one cycle, en_hr=0; mode=3 inc press -> clr_sec one cycle.
REQ-039 Auto-repeat: REPEAT_DLY=10, REPEAT_PER=4, btn_inc held 25 cycles in SET_HR -> en_hr pulses at press+1, +11, +15, +19, +23; none after release.
REQ-040 Collision: btn_mode and btn_inc rise in the same cycle in SET_HR -> mode=2, no en_hr; held inc gives no pulse until re-pressed.
REQ-041 Reset mid-repeat: rst during a held-inc repeat in SET_MIN -> mode=0 and all outputs 0 the next cycle, with no en_min afterwards.
